// File: rtl/illm_stream_fire_ctrl_if.sv
// Lane bundle for one side of the IDCT page: N valid bits, N end-of-stream flags
// and N back-pressure bits travelling against the data.
interface illm_stream_fire_ctrl_if #(
    parameter int N = 8
) ();
    logic [N-1:0] v;
    logic [N-1:0] e;
    logic [N-1:0] b;

    // The producer drives valid/eos; the consumer answers with back-pressure.
    modport master (output v, output e, input b);
    modport slave  (input v, input e, output b);
endinterface

// File: rtl/illm_stream_fire_ctrl.sv
// Firing controller for an N-in/N-out streaming IDCT page: joins the input lanes,
// tracks the LAT-deep datapath, and closes the stream with one EOS token per lane.
module illm_stream_fire_ctrl #(
    parameter int N   = 8,
    parameter int LAT = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    illm_stream_fire_ctrl_if.slave  a,
    illm_stream_fire_ctrl_if.master b,
    output logic                 fire,
    output logic                 dp_en,
    output logic [1:0]           statecase,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EOS   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT-1:0]   vld;
    logic [LAT-1:0]   vld_nxt;
    logic             stall;
    logic             all_data;
    logic             all_eos;
    logic             mixed_eos;
    logic             eos_take;
    logic             err_set;
    logic [N-1:0]     a_b_int;
    logic [N-1:0]     b_v_int;
    logic [N-1:0]     b_e_int;

    assign all_data  = (&a.v) & ~(|a.e);
    assign all_eos   = (&a.v) & (&a.e);
    assign mixed_eos = (&a.v) & (|a.e) & ~(&a.e);

    // A bubble at the output never stalls; only a held beat meets back-pressure.
    assign stall = vld[LAT-1] & (|b.b);

    generate
        if (LAT == 1) begin : g_vld_one
            assign vld_nxt = fire;
        end else begin : g_vld_many
            assign vld_nxt = {vld[LAT-2:0], fire};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            vld   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (dp_en) begin
                vld <= vld_nxt;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // All lanes are consumed together or not at all, so the join stays lockstep.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        eos_take  = 1'b0;
        err_set   = 1'b0;
        dp_en     = ~stall;
        b_v_int   = {N{vld[LAT-1]}};
        b_e_int   = '0;
        case (state)
            ST_RUN: begin
                fire     = all_data & ~stall;
                eos_take = all_eos & ~stall;
                err_set  = mixed_eos;
                if (eos_take) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (vld == '0) begin
                    state_nxt = ST_EOS;
                end
            end
            ST_EOS: begin
                dp_en   = 1'b0;
                b_v_int = '1;
                b_e_int = '1;
                if (~(|b.b)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                b_v_int = '0;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        a_b_int = ~{N{fire | eos_take}};
    end

    assign a.b       = a_b_int;
    assign b.v       = b_v_int;
    assign b.e       = b_e_int;
    assign statecase = state;

    a_fire_needs_all_valid : assert property (@(posedge clock) disable iff (!reset)
        fire |-> (&a.v));
    a_no_fire_when_stalled : assert property (@(posedge clock) disable iff (!reset)
        stall |-> !fire);
    a_eos_holds_pipe : assert property (@(posedge clock) disable iff (!reset)
        (state == ST_EOS) |-> !dp_en);

endmodule
